bcd_count_7: RTL and testbench

- Two-digit (00–99) BCD up-counter with a programmable terminal count.
- While run is low, the counter is cleared and the terminal count is loaded from a 7-bit binary input.
- While run is high, it counts up one per clock and stops at the loaded terminal count.
- Used as a timer/counter front end feeding BCD display logic.

---
 rtl/bcd_count_7.sv | 81 ++++++++
 tb/tb_bcd_count_7.sv | 113 +++++++++++
 2 files changed

// File: rtl/bcd_count_7.sv
// Two-digit BCD up-counter (00-99) with a terminal count loaded while run is low.
// Optional build macro BCD_COUNT_WRAP_EN: roll over to 00 at the terminal count instead of holding.
module bcd_count_7 (
  input  logic       CLK,
  input  logic       RST,
  input  logic [6:0] max_count,
  input  logic       run,
  output logic [3:0] digit_1,
  output logic [3:0] digit_2
);

  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] max_ones_q, max_ones_d;
  logic [3:0] max_tens_q, max_tens_d;

  logic [6:0] clamped;
  logic [3:0] load_tens;
  logic [3:0] load_ones;
  logic       at_max;

  // Binary-to-BCD of the clamped terminal count by threshold search over tens.
  always_comb begin
    clamped   = (max_count > 7'd99) ? 7'd99 : max_count;
    load_tens = 4'd0;
    for (int t = 1; t <= 9; t++) begin
      if (clamped >= 7'(10 * t)) begin
        load_tens = 4'(t);
      end
    end
    load_ones = 4'(clamped - 7'(10 * load_tens));
  end

  assign at_max = (ones_q == max_ones_q) && (tens_q == max_tens_q);

  always_comb begin
    ones_d     = ones_q;
    tens_d     = tens_q;
    max_ones_d = max_ones_q;
    max_tens_d = max_tens_q;
    if (!run) begin
      ones_d     = 4'd0;
      tens_d     = 4'd0;
      max_ones_d = load_ones;
      max_tens_d = load_tens;
    end else if (!at_max) begin
      if (ones_q == 4'd9) begin
        ones_d = 4'd0;
        tens_d = tens_q + 4'd1;
      end else begin
        ones_d = ones_q + 4'd1;
      end
    end else begin
`ifdef BCD_COUNT_WRAP_EN
      ones_d = 4'd0;
      tens_d = 4'd0;
`else
      ones_d = ones_q;
      tens_d = tens_q;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ones_q     <= 4'd0;
      tens_q     <= 4'd0;
      max_ones_q <= 4'd0;
      max_tens_q <= 4'd0;
    end else begin
      ones_q     <= ones_d;
      tens_q     <= tens_d;
      max_ones_q <= max_ones_d;
      max_tens_q <= max_tens_d;
    end
  end

  assign digit_1 = ones_q;
  assign digit_2 = tens_q;

endmodule

// File: tb/tb_bcd_count_7.sv
// Scoreboard bench for bcd_count_7: an integer reference model queues the expected
// count for every edge, and a monitor compares the displayed digits after each edge.
module tb_bcd_count_7;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [6:0] max_count = 7'd0;
  logic       run = 1'b0;
  logic [3:0] digit_1;
  logic [3:0] digit_2;

  bcd_count_7 dut (
    .CLK       (CLK),
    .RST       (RST),
    .max_count (max_count),
    .run       (run),
    .digit_1   (digit_1),
    .digit_2   (digit_2)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  // Reference model state as plain integers.
  int m_cnt = 0;
  int m_max = 0;

  task automatic step(input logic r, input logic rn, input logic [6:0] mc);
    @(negedge CLK);
    RST       = r;
    run       = rn;
    max_count = mc;
    if (r) begin
      m_cnt = 0;
      m_max = 0;
    end else if (!rn) begin
      m_cnt = 0;
      m_max = (int'(mc) > 99) ? 99 : int'(mc);
    end else if (m_cnt < m_max) begin
      m_cnt = m_cnt + 1;
    end else begin
`ifdef BCD_COUNT_WRAP_EN
      m_cnt = 0;
`endif
    end
    exp_q.push_back(m_cnt);
  endtask

  int         mon_exp;
  logic [7:0] mon_want;

  always @(posedge CLK) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_exp  = exp_q.pop_front();
      mon_want = {4'(mon_exp / 10), 4'(mon_exp % 10)};
      vectors++;
      if ({digit_2, digit_1} !== mon_want) begin
        miscompares++;
        $display("FAIL count vec %0d: got digits %0d%0d, want %0d%0d",
                 vectors, digit_2, digit_1, mon_want[7:4], mon_want[3:0]);
      end
    end
  end

  initial begin
    // Reset with run high, then run with a zero terminal count.
    step(1'b1, 1'b1, 7'd50);
    step(1'b1, 1'b1, 7'd50);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 7'd50);

    // Count to 73 with carries; max_count changed mid-run must be ignored.
    step(1'b0, 1'b0, 7'd73);
    for (int i = 0; i < 180; i++) step(1'b0, 1'b1, (i >= 40) ? 7'd15 : 7'd73);

    // Reload to 15.
    step(1'b0, 1'b0, 7'd15);
    step(1'b0, 1'b0, 7'd15);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 7'd15);

    // Clamp 118 -> 99.
    step(1'b0, 1'b0, 7'd118);
    for (int i = 0; i < 110; i++) step(1'b0, 1'b1, 7'd118);

    // 118 applied while running does not alter a terminal count of 20.
    step(1'b0, 1'b0, 7'd20);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 7'd118);

    // Small terminal count (wrap sequence when the wrap build is enabled).
    step(1'b0, 1'b0, 7'd3);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 7'd3);

    // Randomized: occasional reset, run=0 pulses, random max_count.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1,
           7'($urandom_range(0, 127)));
    end

    repeat (2) @(posedge CLK);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected values left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
